// File: rtl/if_id_queue.sv
// if_id_queue: instruction fetch -> decode decoupling queue.
// Holds {pc, pc_plus_4, inst} entries in a small register-based FIFO so fetch
// can keep running for a few cycles while decode stalls. A flush (taken
// branch / jump redirect) discards every queued entry in one cycle.
// Optional feature macro: IF_ID_PERF_CNT_EN adds saturating stall/flush
// performance counters (ports stall_cnt and flush_cnt).
module if_id_queue #(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int PC_WIDTH          = 32,
   parameter int DEPTH             = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PC_WIDTH-1:0]          in_pc,
   input  logic [PC_WIDTH-1:0]          in_pc_plus_4,
   input  logic [INSTRUCTION_WIDTH-1:0] in_inst,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PC_WIDTH-1:0]          out_pc,
   output logic [PC_WIDTH-1:0]          out_pc_plus_4,
   output logic [INSTRUCTION_WIDTH-1:0] out_inst,
   output logic [$clog2(DEPTH):0]       count
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [31:0]                  stall_cnt,
   output logic [31:0]                  flush_cnt
`endif
);

   // Index width and pointer width (pointer carries one extra wrap bit).
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Instruction presented to decode while the queue is empty (addi x0,x0,0).
   localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INST = INSTRUCTION_WIDTH'(32'h0000_0013);

   typedef struct packed {
      logic [PC_WIDTH-1:0]          pc;
      logic [PC_WIDTH-1:0]          pc_plus_4;
      logic [INSTRUCTION_WIDTH-1:0] inst;
   } entry_t;

   // Entry storage; deliberately not reset, only the pointers/count are.
   entry_t mem [DEPTH];

   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0] count_reg,  count_next;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   entry_t        in_entry;
   entry_t        head_entry;

   // Status flags come straight from registered state, so in_ready never
   // has a combinational path from out_ready.
   assign full   = (count_reg == PW'(DEPTH));
   assign empty  = (count_reg == '0);
   assign push   = in_valid & ~full;
   assign pop    = ~empty & out_ready;
   assign wr_idx = wr_ptr_reg[AW-1:0];
   assign rd_idx = rd_ptr_reg[AW-1:0];

   assign in_entry.pc        = in_pc;
   assign in_entry.pc_plus_4 = in_pc_plus_4;
   assign in_entry.inst      = in_inst;

   // Next-state for pointers and occupancy; flush discards this cycle's push/pop.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         rd_ptr_next = wr_ptr_reg;
         count_next  = '0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_next = count_reg + PW'(1);
            2'b01:   count_next = count_reg - PW'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   // Pointer and occupancy registers; reset outranks flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Capture an accepted fetch entry at the write index (dropped on flush/reset).
   always_ff @(posedge clk) begin
      if (push && !flush && !reset) begin
         mem[wr_idx] <= in_entry;
      end
   end

   assign head_entry = mem[rd_idx];

   // Head outputs: combinational read of the head slot, NOP bubble when empty.
   always_comb begin
      out_valid     = ~empty;
      out_pc        = '0;
      out_pc_plus_4 = '0;
      out_inst      = NOP_INST;
      if (!empty) begin
         out_pc        = head_entry.pc;
         out_pc_plus_4 = head_entry.pc_plus_4;
         out_inst      = head_entry.inst;
      end
   end

   assign in_ready = ~full;
   assign count    = count_reg;

`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_cnt_reg;
   logic [31:0] flush_cnt_reg;
   logic        stall_evt;
   logic        flush_evt;

   // A stall is a valid head that decode refuses; a flush only counts when it
   // actually discards something.
   assign stall_evt = ~empty & ~out_ready;
   assign flush_evt = flush & ~empty;

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (stall_evt && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         end
         if (flush_evt && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
            flush_cnt_reg <= flush_cnt_reg + 32'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Directed testbench for if_id_queue (DEPTH=2). Inputs change 1 ns after the
// rising edge and outputs are sampled at the same point, away from the edge.
// Perf-counter checks are built only when IF_ID_PERF_CNT_EN is defined.
module tb_if_id_queue;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_pc_plus_4;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus_4;
   logic [31:0] out_inst;
   logic [1:0]  count;
`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   int total_checks;
   int passed_checks;

   if_id_queue #(
      .INSTRUCTION_WIDTH (32),
      .PC_WIDTH          (32),
      .DEPTH             (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_pc         (in_pc),
      .in_pc_plus_4  (in_pc_plus_4),
      .in_inst       (in_inst),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_pc_plus_4 (out_pc_plus_4),
      .out_inst      (out_inst),
      .count         (count)
`ifdef IF_ID_PERF_CNT_EN
      ,
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total_checks++;
      if (observed !== expected) begin
         $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
      end else begin
         passed_checks++;
         $display("ok   %s: %0h", tag, observed);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] inst);
      in_valid     = v;
      in_pc        = pc;
      in_pc_plus_4 = pc + 32'd4;
      in_inst      = inst;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      total_checks  = 0;
      passed_checks = 0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive_in(1'b0, 32'h0, 32'h0);
      do_reset();

      // 1: idle after reset
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_count",     64'(count),     64'd0);
      check("rst_out_inst",  64'(out_inst),  64'h13);
      check("rst_out_pc",    64'(out_pc),    64'd0);

      // 2: single push with decode stalled, head held stable
      drive_in(1'b1, 32'h0, 32'h0050_0093);
      tick();
      drive_in(1'b0, 32'hDEAD_0000, 32'hFFFF_FFFF);
      check("p1_out_valid", 64'(out_valid),     64'd1);
      check("p1_out_pc",    64'(out_pc),        64'h0);
      check("p1_out_pc4",   64'(out_pc_plus_4), 64'h4);
      check("p1_out_inst",  64'(out_inst),      64'h0050_0093);
      check("p1_count",     64'(count),         64'd1);
      tick();
      tick();
      check("p1_hold_inst",  64'(out_inst),  64'h0050_0093);
      check("p1_hold_count", 64'(count),     64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("p1_pop_count", 64'(count),     64'd0);
      check("p1_pop_valid", 64'(out_valid), 64'd0);
      check("p1_pop_inst",  64'(out_inst),  64'h13);

      // 3: fill to full, third entry refused, full+pop still refuses push
      drive_in(1'b1, 32'h0, 32'hA000_0000);
      tick();
      drive_in(1'b1, 32'h4, 32'hA000_0001);
      tick();
      check("full_count",    64'(count),    64'd2);
      check("full_in_ready", 64'(in_ready), 64'd0);
      drive_in(1'b1, 32'h8, 32'hA000_0002);
      tick();
      check("full_refuse_count", 64'(count),  64'd2);
      check("full_head_pc",      64'(out_pc), 64'h0);
      check("full_head_inst",    64'(out_inst), 64'hA000_0000);
      out_ready = 1'b1;
      tick();
      check("fullpop_count",   64'(count),    64'd1);
      check("fullpop_head_pc", 64'(out_pc),   64'h4);
      check("fullpop_inst",    64'(out_inst), 64'hA000_0001);
      drive_in(1'b0, 32'h0, 32'h0);
      tick();
      check("drain_count", 64'(count),     64'd0);
      check("drain_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // 4: steady push+pop with one entry resident, pointers wrap
      drive_in(1'b1, 32'h0, 32'hB000_0000);
      tick();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check("stream_pre_pc", 64'(out_pc), 64'(32'(4 * (i - 1))));
         drive_in(1'b1, 32'(4 * i), 32'hB000_0000 + 32'(i));
         tick();
         check("stream_count", 64'(count),    64'd1);
         check("stream_pc",    64'(out_pc),   64'(32'(4 * i)));
         check("stream_inst",  64'(out_inst), 64'(32'hB000_0000 + 32'(i)));
      end
      drive_in(1'b0, 32'h0, 32'h0);
      tick();
      check("stream_drain_count", 64'(count), 64'd0);
      out_ready = 1'b0;

      // 5: flush while full with a concurrent push and pop
      drive_in(1'b1, 32'h40, 32'hC000_0000);
      tick();
      drive_in(1'b1, 32'h44, 32'hC000_0001);
      tick();
      check("preflush_count", 64'(count), 64'd2);
      flush     = 1'b1;
      out_ready = 1'b1;
      drive_in(1'b1, 32'h48, 32'hC000_0002);
      tick();
      flush     = 1'b0;
      out_ready = 1'b0;
      drive_in(1'b0, 32'h0, 32'h0);
      check("flush_count",    64'(count),     64'd0);
      check("flush_valid",    64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready),  64'd1);
      check("flush_inst",     64'(out_inst),  64'h13);
      tick();
      check("flush_stays_empty", 64'(out_valid), 64'd0);
      drive_in(1'b1, 32'h50, 32'hC000_0050);
      tick();
      drive_in(1'b0, 32'h0, 32'h0);
      check("postflush_pc",    64'(out_pc),   64'h50);
      check("postflush_inst",  64'(out_inst), 64'hC000_0050);
      check("postflush_count", 64'(count),    64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("postflush_empty", 64'(out_valid), 64'd0);

      // Reset in the middle of traffic, and reset beats flush
      drive_in(1'b1, 32'h60, 32'hD000_0000);
      tick();
      drive_in(1'b0, 32'h0, 32'h0);
      flush = 1'b1;
      reset = 1'b1;
      tick();
      flush = 1'b0;
      reset = 1'b0;
      check("midrst_count", 64'(count),     64'd0);
      check("midrst_valid", 64'(out_valid), 64'd0);

`ifdef IF_ID_PERF_CNT_EN
      // 6: perf counters
      do_reset();
      check("perf_rst_stall", 64'(stall_cnt), 64'd0);
      check("perf_rst_flush", 64'(flush_cnt), 64'd0);
      drive_in(1'b1, 32'h70, 32'hE000_0000);
      tick();
      drive_in(1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      check("perf_stall_5", 64'(stall_cnt), 64'd5);
      flush     = 1'b1;
      out_ready = 1'b1;
      tick();
      check("perf_flush_1",     64'(flush_cnt), 64'd1);
      check("perf_stall_after", 64'(stall_cnt), 64'd5);
      tick();
      flush     = 1'b0;
      out_ready = 1'b0;
      check("perf_empty_flush", 64'(flush_cnt), 64'd1);
`endif

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
